// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch shared definitions: next-PC op encodings and PC helpers.
// IFU_JR_EN (see npc_calc) enables the register-indirect jump target.
package ifu_fetch_pkg;

    typedef enum logic [1:0] {
        NPC_PLUS4  = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JUMP   = 2'b10,
        NPC_JR     = 2'b11
    } npc_op_e;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/ifu_fetch_npc.sv
// npc_calc: combinational next-PC selection for the fetch unit.
// IFU_JR_EN defined: NPCOp=11 jumps to rs_data; otherwise it acts as PLUS4.
module npc_calc
    import ifu_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [1:0]  NPCOp,
    input  logic [31:0] rs_data,
    output logic [31:0] npc
);

    logic [31:0] seq_pc;

    assign seq_pc = pc + PC_STEP;

    always_comb begin
        npc = seq_pc;
        unique case (NPCOp)
            NPC_BRANCH: npc = seq_pc + br_offset(instr[15:0]);
            NPC_JUMP:   npc = {seq_pc[31:28], instr[25:0], 2'b00};
`ifdef IFU_JR_EN
            NPC_JR:     npc = {rs_data[31:2], 2'b00};
`endif
            default:    npc = seq_pc;
        endcase
    end

`ifdef IFU_JR_EN
    logic unused_bits;
    assign unused_bits = ^{instr[31:26], rs_data[1:0]};
`else
    logic unused_bits;
    assign unused_bits = ^{instr[31:26], rs_data};
`endif

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: multi-cycle instruction fetch with PC, handshake and retire count.
// IFU_JR_EN (in npc_calc) selects whether NPCOp=11 is a register jump.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic [1:0]  NPCOp,
    input  logic [31:0] rs_data,
    input  logic        commit,
    output logic [31:0] icount
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2
    } state_e;

    state_e      state;
    state_e      state_n;
    logic        load_instr;
    logic        retire;
    logic [31:0] npc;

    npc_calc u_npc (
        .pc      (pc),
        .instr   (instr),
        .NPCOp   (NPCOp),
        .rs_data (rs_data),
        .npc     (npc)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_FETCH;
        else       state <= state_n;
    end

    always_comb begin
        state_n    = state;
        imem_req   = 1'b0;
        load_instr = 1'b0;
        retire     = 1'b0;
        unique case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) state_n = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    load_instr = 1'b1;
                    state_n    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (commit) begin
                    retire  = 1'b1;
                    state_n = S_FETCH;
                end
            end
            default: state_n = S_FETCH;
        endcase
    end

    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc          <= RESET_PC;
            pc_plus4    <= RESET_PC + PC_STEP;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            icount      <= 32'h0;
        end else begin
            if (load_instr) begin
                instr       <= imem_rdata;
                instr_valid <= 1'b1;
            end
            if (retire) begin
                pc          <= npc;
                pc_plus4    <= npc + PC_STEP;
                icount      <= icount + 32'd1;
                instr_valid <= 1'b0;
            end
        end
    end

endmodule
